// File: rtl/nb_access_pkg.sv
// Shared constants and FSM state type for the neuron-buffer access controller.
package nb_access_pkg;
    localparam int unsigned NxTn       = 256;
    localparam int unsigned ADDR       = 6;
    localparam int unsigned NUM_WORDS  = 64;
    localparam int unsigned LEN_W      = 7;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic WEN_WRITE = 1'b0;
    localparam logic WEN_IDLE  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } nb_state_e;
endpackage

// File: rtl/nb_rd_fifo.sv
// Read-data FIFO between the NB Q port and the compute consumer.
// Depth must be a power of two so the pointers wrap naturally.
module nb_rd_fifo #(
    parameter int unsigned Width = 256,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic [$clog2(Depth):0] count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push_i && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/nb_access_ctrl.sv
// Arbitrates the single-port NB between single-word writes and burst reads.
// Define NB_ACCESS_CTRL_PERF_EN to add 32-bit grant/stall performance counters.
module nb_access_ctrl
    import nb_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR-1:0]   i_wr_addr,
    input  logic [NxTn-1:0]   i_wr_data,
    input  logic              i_rd_start,
    input  logic [ADDR-1:0]   i_rd_base,
    input  logic [LEN_W-1:0]  i_rd_len,
    output logic              o_rd_busy,
    output logic              o_rd_done,
    output logic [NxTn-1:0]   o_rd_data,
    output logic              o_rd_dvalid,
    input  logic              i_rd_dready,
    output logic              o_mem_wen,
    output logic [ADDR-1:0]   o_mem_addr,
    output logic [NxTn-1:0]   o_mem_wdata,
    input  logic [NxTn-1:0]   i_mem_rdata
`ifdef NB_ACCESS_CTRL_PERF_EN
    ,
    output logic [31:0]       o_perf_wr_cnt,
    output logic [31:0]       o_perf_rd_cnt,
    output logic [31:0]       o_perf_stall_cnt
`endif
);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CredW = CntW + 1;

    nb_state_e        state_q, state_d;
    logic [ADDR-1:0]  addr_q, addr_d, hold_addr_q;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             inflight_q, rr_q, rr_d, done_q, done_d;
    logic [CntW-1:0]  fifo_cnt;
    logic [CredW-1:0] credit;
    logic             rd_elig, wr_gnt, rd_gnt;

    assign credit  = CredW'(fifo_cnt) + CredW'(inflight_q);
    assign rd_elig = (state_q == StBurst) && (credit < CredW'(FIFO_DEPTH));

    // rr_q set means the read side wins the next contended cycle.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        rr_d   = rr_q;
        if (rst_n) begin
            if (i_wr_valid && rd_elig) begin
                rd_gnt = rr_q;
                wr_gnt = !rr_q;
                rr_d   = !rr_q;
            end else begin
                wr_gnt = i_wr_valid;
                rd_gnt = rd_elig;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remain_q    <= '0;
            inflight_q  <= 1'b0;
            rr_q        <= 1'b1;
            done_q      <= 1'b0;
            hold_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            inflight_q  <= rd_gnt;
            rr_q        <= rr_d;
            done_q      <= done_d;
            hold_addr_q <= o_mem_addr;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_rd_start) begin
                    if (i_rd_len != '0) begin
                        addr_d   = i_rd_base;
                        remain_d = i_rd_len;
                        state_d  = StBurst;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StBurst: begin
                if (rd_gnt) begin
                    addr_d   = ADDR'((32'(addr_q) + 32'd1) % NUM_WORDS);
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((fifo_cnt == '0) && !inflight_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_mem_wen   = WEN_IDLE;
        o_mem_addr  = hold_addr_q;
        o_mem_wdata = '0;
        if (wr_gnt) begin
            o_mem_wen   = WEN_WRITE;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
        end else if (rd_gnt) begin
            o_mem_addr = addr_q;
        end
    end

    assign o_wr_ready  = wr_gnt;
    assign o_rd_busy   = (state_q != StIdle);
    assign o_rd_done   = done_q;
    assign o_rd_dvalid = (fifo_cnt != '0);

    nb_rd_fifo #(
        .Width (NxTn),
        .Depth (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (inflight_q),
        .wdata_i (i_mem_rdata),
        .pop_i   (o_rd_dvalid && i_rd_dready),
        .rdata_o (o_rd_data),
        .count_o (fifo_cnt)
    );

`ifdef NB_ACCESS_CTRL_PERF_EN
    logic [31:0] perf_wr_q, perf_rd_q, perf_stall_q;
    logic        stall;

    assign stall = (i_wr_valid && !wr_gnt) || (rd_elig && !rd_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wr_q    <= '0;
            perf_rd_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_wr_q    <= perf_wr_q + 32'(wr_gnt);
            perf_rd_q    <= perf_rd_q + 32'(rd_gnt);
            perf_stall_q <= perf_stall_q + 32'(stall);
        end
    end

    assign o_perf_wr_cnt    = perf_wr_q;
    assign o_perf_rd_cnt    = perf_rd_q;
    assign o_perf_stall_cnt = perf_stall_q;
`endif
endmodule
